// File: rtl/alu_seq.sv
// Registered ALU with Start/Busy/Done handshake: single-cycle logic/add/slt,
// iterative shift-add multiply and restoring divide/remainder (WIDTH cycles).
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bnegate,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carryout,
  output logic             divzero
);

  localparam logic [2:0] OP_AND = 3'b000, OP_OR   = 3'b001, OP_ADD  = 3'b010,
                         OP_SLT = 3'b011, OP_XOR  = 3'b100, OP_MULU = 3'b101,
                         OP_DIVU = 3'b110, OP_REMU = 3'b111;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] opnd;   // multiplicand or divisor
  logic [WIDTH-1:0] hi;     // product high half or partial remainder
  logic [WIDTH-1:0] lo;     // multiplier shifting out or quotient shifting in

  logic accept, iter_op, last;
  assign accept  = start && (state != RUN);
  assign iter_op = (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  assign last    = (cnt == CW'(1));

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH-1:0] bb, alu_res;
  logic [WIDTH:0]   sum, dif;
  logic             add_ov, slt_ov, alu_ov, alu_co;

  always_comb begin
    bb     = bnegate ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, bnegate};
    // carry into MSB is a^b^sum at that bit; overflow is it XOR carry out
    add_ov = a[WIDTH-1] ^ bb[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH];
    dif    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    slt_ov = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_co  = 1'b0;
    case (op)
      OP_AND: alu_res = a & bb;
      OP_OR:  alu_res = a | bb;
      OP_XOR: alu_res = a ^ bb;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_ov  = add_ov;
        alu_co  = sum[WIDTH];
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, dif[WIDTH-1] ^ slt_ov};
      default: ;
    endcase
  end

  // ---------------- iterative step ----------------
  logic [WIDTH:0]   mstep, dshift;
  logic [WIDTH-1:0] dsub, hi_nx, lo_nx;
  logic             dge;

  always_comb begin
    mstep  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    dshift = {hi, lo[WIDTH-1]};
    dge    = dshift >= {1'b0, opnd};
    // when dge the difference is below the divisor, so WIDTH bits suffice
    dsub   = dshift[WIDTH-1:0] - opnd;
    if (op_r == OP_MULU) begin
      hi_nx = mstep[WIDTH:1];
      lo_nx = {mstep[0], lo[WIDTH-1:1]};
    end else begin
      hi_nx = dge ? dsub : dshift[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], dge};
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nx = iter_op ? RUN : DONE;
        else       state_nx = IDLE;
      end
      RUN:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // ---------------- datapath / result registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_r     <= OP_AND;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      result   <= '0;
      overflow <= 1'b0;
      carryout <= 1'b0;
      divzero  <= 1'b0;
    end else if (accept) begin
      if (iter_op) begin
        op_r <= op;
        opnd <= (op == OP_MULU) ? a : b;
        hi   <= '0;
        lo   <= (op == OP_MULU) ? b : a;
        cnt  <= CW'(WIDTH);
      end else begin
        result   <= alu_res;
        overflow <= alu_ov;
        carryout <= alu_co;
        divzero  <= 1'b0;
      end
    end else if (state == RUN) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt - CW'(1);
      if (last) begin
        result   <= (op_r == OP_REMU) ? hi_nx : lo_nx;
        overflow <= (op_r == OP_MULU) && (|hi_nx);
        carryout <= 1'b0;
        divzero  <= (op_r != OP_MULU) && (opnd == '0);
      end
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16): results, flags,
// latency, handshake corner cases and asynchronous reset mid-operation.
module tb_alu_seq;
  localparam int W = 16;
  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD = 3'b010, SLT = 3'b011,
                         XOR_ = 3'b100, MULU = 3'b101, DIVU = 3'b110, REMU = 3'b111;

  logic         clk, rst_n, start, bnegate;
  logic [W-1:0] a, b, result;
  logic [2:0]   op;
  logic         busy, done, zero, overflow, carryout, divzero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bnegate(bnegate),
    .op(op), .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .carryout(carryout), .divzero(divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [W-1:0] er, input logic eo,
                           input logic ec, input logic ed);
    chk({tag, "/res"},  32'(result),   32'(er));
    chk({tag, "/zero"}, 32'(zero),     32'(er == '0));
    chk({tag, "/ovf"},  32'(overflow), 32'(eo));
    chk({tag, "/cout"}, 32'(carryout), 32'(ec));
    chk({tag, "/dz"},   32'(divzero),  32'(ed));
  endtask

  // Issue one op and wait (bounded) for Done; inputs are scrambled while busy
  // to show operands are latched, and Start may be pulsed at RUN cycle 'glitch'.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic xbn, input logic [W-1:0] er,
                        input logic eo, input logic ec, input logic ed,
                        input int elat, input int glitch);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb; bnegate = xbn;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      chk({tag, "/busy"}, 32'(busy), 32'd1);
      a = W'($urandom); b = W'($urandom); op = 3'($urandom); bnegate = 1'($urandom);
      if (lat == glitch) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk({tag, "/lat"},     32'(lat),  32'(elat));
    chk({tag, "/busydone"}, 32'(busy), 32'd0);
    chk_flags(tag, er, eo, ec, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = AND_; bnegate = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk_flags("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    run_op("add_ovf",  ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1, 0);
    run_op("sub_eq",   ADD,  16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 0);
    run_op("slt_ovf",  SLT,  16'h8000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("slt_ge",   SLT,  16'h0001, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("and_neg",  AND_, 16'hF0F0, 16'h0FF0, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("or",       OR_,  16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("xor",      XOR_, 16'h1234, 16'hFFFF, 1'b0, 16'hEDCB, 1'b0, 1'b0, 1'b0, 1, 0);

    run_op("mulu",     MULU, 16'h0123, 16'h0010, 1'b0, 16'h1230, 1'b0, 1'b0, 1'b0, 17, 5);
    repeat (3) @(negedge clk);
    chk("hold_idle/res",  32'(result), 32'h1230);
    chk("hold_idle/done", 32'(done),   32'd0);
    run_op("mulu_ovf", MULU, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 17, 0);

    run_op("divu",     DIVU, 16'd100,  16'd7,    1'b0, 16'd14,   1'b0, 1'b0, 1'b0, 17, 0);
    run_op("remu",     REMU, 16'd100,  16'd7,    1'b0, 16'd2,    1'b0, 1'b0, 1'b0, 17, 0);
    run_op("divu_z",   DIVU, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 17, 0);
    run_op("remu_z",   REMU, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 17, 0);

    // Start in the Done cycle is accepted
    start = 1'b1; op = ADD; a = 16'd2; b = 16'd3; bnegate = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b/done", 32'(done), 32'd1);
    chk_flags("b2b", 16'h0005, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b/pulse", 32'(done),   32'd0);
    chk("b2b/hold",  32'(result), 32'h0005);

    // Asynchronous reset at RUN cycle 8 of a divide
    @(negedge clk);
    start = 1'b1; op = DIVU; a = 16'h1234; b = 16'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 8) begin @(negedge clk); lat++; end
    chk("rstrun/busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstrun/busy", 32'(busy), 32'd0);
    chk("rstrun/done", 32'(done), 32'd0);
    chk_flags("rstrun", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("rstrun/no_done", 32'(seen), 32'd0);
    run_op("add_after", ADD, 16'd1, 16'd1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU for the CPU datapath with a Start/Busy/Done handshake. Logic, add/subtract and set-less-than complete in one cycle. Unsigned multiply, divide and remainder are iterative and take WIDTH cycles. Operands are captured at Start, and Result plus flags are held stable until the next accepted Start, so the control unit can stall on Busy.

## Interface
- WIDTH, 16: operand and result width; must be ≥ 2.
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  request; accepted on a rising edge when Busy=0.
- A  in  WIDTH  operand A, captured at accept.
- B  in  WIDTH  operand B, captured at accept.
- BNegate  in  1  replaces B with ~B and sets carry-in to 1; applies only to Op 000/001/010/100.
- Op  in  3  000 AND, 001 OR, 010 ADD/SUB, 011 SLT, 100 XOR, 101 MULU, 110 DIVU, 111 REMU.
- Busy  out  1  iterative operation in progress.
- Done  out  1  one-cycle pulse: Result and flags are valid.
- Result  out  WIDTH  registered result.
- Zero  out  1  Result == 0.
- Overflow  out  1  signed overflow (ADD/SUB), or nonzero upper product half (MULU).
- CarryOut  out  1  carry out of the MSB (ADD/SUB only).
- DivZero  out  1  divisor was 0 (DIVU/REMU).

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with Start=1 and a one-cycle op: compute, register Result and flags, go to DONE.
- IDLE or DONE with Start=1 and Op 101–111: latch operands, clear the accumulator, load the counter with WIDTH, go to RUN.
- RUN: perform one iteration per cycle and decrement the counter. When the counter reaches 0, register Result and flags and go to DONE.
- DONE without Start: go to IDLE. Done=1 only in DONE.
- ADD/SUB: {CarryOut, Result} = A + B' + BNegate, where B' = BNegate ? ~B : B.
  - Overflow = carry into the MSB XOR carry out of the MSB.
  - Subtract with no borrow gives CarryOut=1.
- SLT: always computes A−B, ignoring BNegate. Result = zero-extended (sign XOR overflow), i.e. a correct signed compare.
  - Overflow=0, CarryOut=0.
- AND, OR, XOR: use B'. Overflow=0, CarryOut=0.
- MULU: shift-add over a 2·WIDTH product.
  - Result = low WIDTH bits.
  - Overflow = |high WIDTH bits.
- DIVU/REMU: restoring division, one quotient bit per cycle.
  - DIVU gives the quotient; REMU gives the remainder.
  - Overflow=0, CarryOut=0.
- Divide by zero: still takes WIDTH cycles. DIVU gives all ones; REMU gives A; DivZero=1.
- DivZero=0 for every other op.
- Zero always reflects the registered Result.

## Timing
- Reset (asynchronous, any state including mid-RUN):
  - State goes to IDLE and the operation is aborted.
  - Busy=0, Done=0, Result=0, Zero=1, Overflow=0, CarryOut=0, DivZero=0.
- Start sampled at edge E0:
  - One-cycle op: Done=1 in the cycle after E0, latency 1.
  - Iterative op: Busy=1 for WIDTH cycles after E0. Done=1 in cycle WIDTH+1, where Busy has returned to 0. Latency WIDTH+1.
- Busy and Done are never both 1.
- Start while Busy=1 is ignored, with no queuing. A, B and Op may change freely during RUN.
- Start in the Done cycle is accepted (back-to-back). That Done still pulses for exactly one cycle.
- Result and flags change only on the edge entering DONE, or on reset. They hold through IDLE.
- Arithmetic is modulo 2^WIDTH. There are no combinational paths from inputs to outputs.

## Test plan
- ADD, WIDTH=16: A=0x7FFF, B=0x0001, BNegate=0.
  - Done one cycle later; Result=0x8000, Overflow=1, CarryOut=0, Zero=0.
- SUB: A=B=0x0005, BNegate=1.
  - Result=0x0000, Zero=1, CarryOut=1, Overflow=0.
  - Then SLT with A=0x8000, B=0x0001 gives Result=0x0001. The bench must check this overflowing case.
- MULU: A=0x0123, B=0x0010.
  - Busy for 16 cycles; Done in cycle 17; Result=0x1230, Overflow=0.
  - Then A=B=0x0100 gives Result=0x0000, Zero=1, Overflow=1.
- DIVU/REMU: A=100, B=7 gives quotient 14 and remainder 2.
  - A=0x1234, B=0 gives DIVU=0xFFFF and REMU=0x1234, both with DivZero=1 and 17-cycle latency.
- Handshake:
  - Start pulsed at RUN cycle 5 of a MULU: ignored, and the original result is unchanged.
  - Start in the Done cycle with ADD 2+3: Done one cycle later with Result=0x0005.
- Reset: Reset_n low for one cycle during RUN cycle 8 of a DIVU.
  - All outputs at reset values immediately, Busy=0, no Done.
  - A following ADD 1+1 gives Result=0x0002.
